sprite_reg_ctrl: RTL and testbench
==================================

// Module: sprite_reg_ctrl
// PURPOSE
//  Avalon-MM configuration controller for the sprite display datapath. Holds shadow copies of per-sprite X/Y/enable,
//  commits them atomically to the active set driving the sprite compositor at vertical-blank start (no tearing),
//  and exposes status, a frame counter and an optional frame IRQ. Sits between the HPS bridge and the display engine.
// PARAMETERS
//  NUM_SPRITES  8     sprite slots (1..32)
//  COORD_W      10    coordinate width per axis
//  VACTIVE      480   active lines; vblank starts at vcount==VACTIVE
// PORTS
//  clk          in   1                   system clock (50 MHz)
//  reset        in   1                   synchronous, active-high
//  chipselect   in   1                   Avalon-MM select
//  write        in   1                   Avalon-MM write strobe
//  read         in   1                   Avalon-MM read strobe
//  address      in   9                   word address
//  writedata    in   32                  write data
//  readdata     out  32                  read data, registered
//  hcount       in   11                  from vga_counters
//  vcount       in   10                  from vga_counters
//  sprite_x     out  NUM_SPRITES*COORD_W active X, slot i at [i*COORD_W +: COORD_W]
//  sprite_y     out  NUM_SPRITES*COORD_W active Y, same packing
//  sprite_en    out  NUM_SPRITES         active enable mask
//  commit_pulse out  1                   1-cycle pulse when active set updates
//  irq          out  1                   frame interrupt (0 unless FRAME_IRQ_EN)
// BEHAVIOUR
//  Register map: 2i=X[i], 2i+1=Y[i] (i<NUM_SPRITES, R/W shadow); 0x40 ENABLE (R/W shadow, bits NUM_SPRITES-1:0);
//   0x41 CONTROL: bit0 write-1 commit request (reads 0), bit1 AUTO (R/W); 0x42 STATUS (RO): bit0 pending,
//   bit1 in_vblank (vcount>=VACTIVE); 0x43 FRAME_COUNT (RO, 16b); 0x44 IRQ (FRAME_IRQ_EN only).
//  Writes take writedata[COORD_W-1:0] (ENABLE: [NUM_SPRITES-1:0]); upper bits ignored. Unmapped writes ignored;
//   unmapped reads return 0. readdata valid cycle after read&chipselect; holds value otherwise.
//  Reset: all shadow/active X,Y=0, enable=0, AUTO=1, frame_count=0, readdata=0, commit_pulse=0, irq=0, state IDLE.
//  vblank_start event: single cycle where hcount==0 && vcount==VACTIVE.
//  FSM: IDLE -> PENDING on commit-request write. PENDING -> COMMIT on vblank_start. IDLE -> COMMIT on vblank_start
//   if AUTO=1. COMMIT (1 cycle): active <= shadow, commit_pulse=1 -> IDLE. Active outputs change on COMMIT exit edge.
//  Simultaneous events: commit request in same cycle as vblank_start -> PENDING, commits next frame (unless AUTO).
//   Shadow write in COMMIT cycle: copy takes pre-write shadow; new value waits for next commit. Commit request
//   while PENDING/COMMIT: absorbed (COMMIT -> PENDING if request lands in COMMIT cycle).
//  frame_count +1 at each vblank_start, wraps 0xFFFF->0.
//  Reset mid-frame: immediate return to reset state; pending commit discarded.
// CONFIGURATION
//  FRAME_IRQ_EN defined: irq set at vblank_start; cleared by any write to 0x44; set wins on same cycle;
//   read 0x44 bit0 = irq. Undefined: irq tied 0, 0x44 unmapped (reads 0, writes ignored).
// STRUCTURE
//  sprite_ctrl_pkg: register address localparams (REG_ENABLE..REG_IRQ), state enum {IDLE,PENDING,COMMIT},
//   reset defaults. Sub-module sprite_vblank_detect: hcount/vcount -> vblank_start pulse, in_vblank level.
// TESTING
//  AUTO=0, write X[0]=0x123, request commit, run to vcount=480,hcount=0 -> sprite_x[0] still 0 until commit, then 0x123, commit_pulse 1 cycle.
//  AUTO=1, write Y[3]=0x050 mid-frame -> sprite_y slot 3 unchanged until next vblank_start, then 0x050.
//  AUTO=0, request commit on exact vblank_start cycle -> no update that frame; updates at following vblank_start.
//  Write X[1] during COMMIT cycle -> active X[1] gets old shadow; new value after next commit.
//  Read 0x43 across 3 vblanks from reset -> 0,1,2,3; read 0x7F -> 0; readdata one cycle after read.
//  FRAME_IRQ_EN: irq rises at vblank_start; write 0x44 -> irq 0; write 0x44 on vblank_start cycle -> irq stays 1.

Source files
------------

// File: rtl/sprite_ctrl_pkg.sv
// Shared definitions for the sprite register controller: register map,
// commit FSM state encoding and reset defaults.
package sprite_ctrl_pkg;

  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] REG_ENABLE      = 9'h040;
  localparam logic [ADDR_W-1:0] REG_CONTROL     = 9'h041;
  localparam logic [ADDR_W-1:0] REG_STATUS      = 9'h042;
  localparam logic [ADDR_W-1:0] REG_FRAME_COUNT = 9'h043;
  localparam logic [ADDR_W-1:0] REG_IRQ         = 9'h044;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } state_t;

  localparam logic        RST_AUTO        = 1'b1;
  localparam logic [15:0] RST_FRAME_COUNT = 16'h0000;

endpackage

// File: rtl/sprite_vblank_detect.sv
// Turns the VGA counters into a one-cycle vertical-blank start pulse and an
// in-blanking level.
module sprite_vblank_detect
  import sprite_ctrl_pkg::*;
#(
  parameter int VACTIVE = 480
) (
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        vblank_start,
  output logic        in_vblank
);

  assign vblank_start = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  assign in_vblank    = (vcount >= 10'(VACTIVE));

endmodule

// File: rtl/sprite_reg_ctrl.sv
// Avalon-MM sprite configuration controller: shadow registers committed atomically
// to the active set at vblank start. Optional frame IRQ enabled by defining FRAME_IRQ_EN.
module sprite_reg_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int COORD_W     = 10,
  parameter int VACTIVE     = 480
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           chipselect,
  input  logic                           write,
  input  logic                           read,
  input  logic [8:0]                     address,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  input  logic [10:0]                    hcount,
  input  logic [9:0]                     vcount,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  output logic [NUM_SPRITES-1:0]         sprite_en,
  output logic                           commit_pulse,
  output logic                           irq
);

  logic wr_en;
  logic rd_en;
  logic commit_req;
  logic vblank_start;
  logic in_vblank;
  logic auto_commit;
  logic [15:0] frame_count;
  logic [31:0] rdata_next;
  logic unused_wdata;

  state_t state;
  state_t next_state;

  logic [COORD_W-1:0]     shadow_x [NUM_SPRITES];
  logic [COORD_W-1:0]     shadow_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] shadow_en;
  logic [COORD_W-1:0]     active_x [NUM_SPRITES];
  logic [COORD_W-1:0]     active_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] active_en;

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign commit_req   = wr_en && (address == REG_CONTROL) && writedata[0];
  assign unused_wdata = ^writedata;

  sprite_vblank_detect #(
    .VACTIVE(VACTIVE)
  ) u_vblank (
    .hcount      (hcount),
    .vcount      (vcount),
    .vblank_start(vblank_start),
    .in_vblank   (in_vblank)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
      shadow_en   <= '0;
      auto_commit <= RST_AUTO;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (address == ADDR_W'(2*i))
          shadow_x[i] <= writedata[COORD_W-1:0];
        if (address == ADDR_W'(2*i+1))
          shadow_y[i] <= writedata[COORD_W-1:0];
      end
      if (address == REG_ENABLE)
        shadow_en <= writedata[NUM_SPRITES-1:0];
      if (address == REG_CONTROL)
        auto_commit <= writedata[1];
    end
  end

  // Copy happens on the edge leaving COMMIT, so a shadow write in that same
  // cycle is not seen by the copy and waits for the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        active_x[i] <= '0;
        active_y[i] <= '0;
      end
      active_en <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        active_x[i] <= shadow_x[i];
        active_y[i] <= shadow_y[i];
      end
      active_en <= shadow_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state   = state;
    commit_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (vblank_start && auto_commit)
          next_state = COMMIT;
        else if (commit_req)
          next_state = PENDING;
      end
      PENDING: begin
        if (vblank_start)
          next_state = COMMIT;
      end
      COMMIT: begin
        commit_pulse = 1'b1;
        next_state   = commit_req ? PENDING : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      frame_count <= RST_FRAME_COUNT;
    else if (vblank_start)
      frame_count <= frame_count + 16'd1;
  end

`ifdef FRAME_IRQ_EN
  logic irq_q;

  // A new frame event takes priority over a clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)
      irq_q <= 1'b0;
    else if (vblank_start)
      irq_q <= 1'b1;
    else if (wr_en && (address == REG_IRQ))
      irq_q <= 1'b0;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (address == ADDR_W'(2*i))
        rdata_next[COORD_W-1:0] = shadow_x[i];
      if (address == ADDR_W'(2*i+1))
        rdata_next[COORD_W-1:0] = shadow_y[i];
    end
    case (address)
      REG_ENABLE:      rdata_next[NUM_SPRITES-1:0] = shadow_en;
      REG_CONTROL:     rdata_next[1] = auto_commit;
      REG_STATUS:      rdata_next[1:0] = {in_vblank, (state == PENDING)};
      REG_FRAME_COUNT: rdata_next[15:0] = frame_count;
`ifdef FRAME_IRQ_EN
      REG_IRQ:         rdata_next[0] = irq_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else if (rd_en)
      readdata <= rdata_next;
  end

  always_comb begin
    sprite_x = '0;
    sprite_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      sprite_x[i*COORD_W +: COORD_W] = active_x[i];
      sprite_y[i*COORD_W +: COORD_W] = active_y[i];
    end
  end

  assign sprite_en = active_en;

endmodule

// File: tb/tb_sprite_reg_ctrl.sv
// Self-checking bench for sprite_reg_ctrl: register-map vector table with a
// readdata scoreboard, plus hand-written commit/vblank timing sequences.
module tb_sprite_reg_ctrl;

  localparam int NS = 8;
  localparam int CW = 10;
  localparam int VA = 480;

  logic              clk = 1'b0;
  logic              reset;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [8:0]        address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic [NS*CW-1:0]  sprite_x;
  logic [NS*CW-1:0]  sprite_y;
  logic [NS-1:0]     sprite_en;
  logic              commit_pulse;
  logic              irq;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  vec_t    vecs[$];
  rd_exp_t exp_q[$];
  logic    rd_seen = 1'b0;
  int      total = 0;
  int      passed = 0;
  int      exp_frames = 0;

  always #5 clk = ~clk;

  sprite_reg_ctrl #(
    .NUM_SPRITES(NS),
    .COORD_W    (CW),
    .VACTIVE    (VA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .hcount      (hcount),
    .vcount      (vcount),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_en   (sprite_en),
    .commit_pulse(commit_pulse),
    .irq         (irq)
  );

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    total++;
    if (actual === expected)
      passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [CW-1:0] slot(input logic [NS*CW-1:0] v, input int i);
    return v[i*CW +: CW];
  endfunction

  // Readdata is due one cycle after the read strobe is sampled.
  always @(posedge clk) rd_seen <= chipselect && read;

  always @(negedge clk) begin
    if (rd_seen && exp_q.size() > 0) begin
      rd_exp_t e;
      e = exp_q.pop_front();
      checkOutput($sformatf("read@0x%0h", e.addr), 96'(readdata), 96'(e.data));
    end
  end

  task automatic applyStimulus(input logic wr, input logic [8:0] addr, input logic [31:0] data,
                               input logic [31:0] exp);
    chipselect = 1'b1;
    write      = wr;
    read       = !wr;
    address    = addr;
    writedata  = data;
    if (!wr)
      exp_q.push_back('{addr, exp});
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic wr_reg(input logic [8:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 32'h0);
  endtask

  task automatic rd_reg(input logic [8:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, addr, 32'h0, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vcount = 10'(VA);
    hcount = 11'd0;
    @(negedge clk);
    exp_frames++;
    hcount = 11'd1;
    @(negedge clk);
    vcount = 10'd100;
    hcount = 11'd10;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    writedata  = '0;
    vcount     = 10'd100;
    hcount     = 11'd10;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_readdata", 96'(readdata), 96'h0);
    checkOutput("rst_sprite_x", 96'(sprite_x), 96'h0);
    checkOutput("rst_sprite_y", 96'(sprite_y), 96'h0);
    checkOutput("rst_sprite_en", 96'(sprite_en), 96'h0);
    checkOutput("rst_commit_pulse", 96'(commit_pulse), 96'h0);
    checkOutput("rst_irq", 96'(irq), 96'h0);

    vecs.push_back('{1'b0, 9'h041, 32'h0, 32'h2});
    vecs.push_back('{1'b0, 9'h042, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 9'h043, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 9'h07F, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 9'h044, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 9'h000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 9'h041, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 9'h041, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 9'h000, 32'hFFFF_F123, 32'h0});
    vecs.push_back('{1'b0, 9'h000, 32'h0, 32'h123});
    vecs.push_back('{1'b1, 9'h005, 32'h0000_03FF, 32'h0});
    vecs.push_back('{1'b0, 9'h005, 32'h0, 32'h3FF});
    vecs.push_back('{1'b1, 9'h00E, 32'h0000_02AA, 32'h0});
    vecs.push_back('{1'b0, 9'h00E, 32'h0, 32'h2AA});
    vecs.push_back('{1'b1, 9'h040, 32'hFFFF_FF05, 32'h0});
    vecs.push_back('{1'b0, 9'h040, 32'h0, 32'h05});
    vecs.push_back('{1'b1, 9'h07F, 32'h0000_0055, 32'h0});
    vecs.push_back('{1'b0, 9'h07F, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 9'h010, 32'h0000_01FF, 32'h0});
    vecs.push_back('{1'b0, 9'h010, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 9'h00F, 32'h0, 32'h0});

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);

    checkOutput("active_x_untouched", 96'(sprite_x), 96'h0);
    checkOutput("active_en_untouched", 96'(sprite_en), 96'h0);

    // Manual commit with AUTO=0: visible only after the COMMIT cycle.
    wr_reg(9'h041, 32'h1);
    rd_reg(9'h042, 32'h1);
    idle(2);
    checkOutput("x0_before_vblank", 96'(slot(sprite_x, 0)), 96'h0);
    vcount = 10'(VA);
    hcount = 11'd0;
    @(negedge clk);
    exp_frames++;
    checkOutput("pulse_in_commit", 96'(commit_pulse), 96'h1);
    checkOutput("x0_during_commit", 96'(slot(sprite_x, 0)), 96'h0);
    hcount = 11'd1;
    @(negedge clk);
    checkOutput("pulse_one_cycle", 96'(commit_pulse), 96'h0);
    checkOutput("x0_after_commit", 96'(slot(sprite_x, 0)), 96'h123);
    checkOutput("y2_after_commit", 96'(slot(sprite_y, 2)), 96'h3FF);
    checkOutput("x7_after_commit", 96'(slot(sprite_x, 7)), 96'h2AA);
    checkOutput("en_after_commit", 96'(sprite_en), 96'h05);
    rd_reg(9'h042, 32'h2);
    rd_reg(9'h043, 32'(exp_frames));
    vcount = 10'd100;
    hcount = 11'd10;

    // Commit request landing exactly on vblank_start defers to the next frame.
    wr_reg(9'h002, 32'h0AB);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 9'h041;
    writedata  = 32'h1;
    vcount     = 10'(VA);
    hcount     = 11'd0;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    exp_frames++;
    hcount = 11'd1;
    checkOutput("no_pulse_same_frame", 96'(commit_pulse), 96'h0);
    @(negedge clk);
    checkOutput("x1_no_commit_same_frame", 96'(slot(sprite_x, 1)), 96'h0);
    rd_reg(9'h042, 32'h3);
    vcount = 10'd100;
    hcount = 11'd10;
    idle(1);
    frame();
    checkOutput("x1_next_frame", 96'(slot(sprite_x, 1)), 96'h0AB);

    // AUTO=1: shadow write during COMMIT keeps the old value in the copy.
    wr_reg(9'h041, 32'h2);
    wr_reg(9'h002, 32'h111);
    vcount = 10'(VA);
    hcount = 11'd0;
    @(negedge clk);
    exp_frames++;
    hcount = 11'd1;
    checkOutput("pulse_auto", 96'(commit_pulse), 96'h1);
    wr_reg(9'h002, 32'h222);
    checkOutput("x1_old_shadow", 96'(slot(sprite_x, 1)), 96'h111);
    rd_reg(9'h002, 32'h222);
    vcount = 10'd100;
    hcount = 11'd10;
    wr_reg(9'h007, 32'h050);
    idle(3);
    checkOutput("y3_before_vblank", 96'(slot(sprite_y, 3)), 96'h0);
    frame();
    checkOutput("y3_after_vblank", 96'(slot(sprite_y, 3)), 96'h050);
    checkOutput("x1_new_shadow", 96'(slot(sprite_x, 1)), 96'h222);

    // Request during COMMIT cycle re-arms PENDING.
    vcount = 10'(VA);
    hcount = 11'd0;
    @(negedge clk);
    exp_frames++;
    hcount = 11'd1;
    wr_reg(9'h041, 32'h3);
    rd_reg(9'h042, 32'h3);
    vcount = 10'd100;
    hcount = 11'd10;
    rd_reg(9'h043, 32'(exp_frames));
    idle(2);
    checkOutput("readdata_hold", 96'(readdata), 96'(exp_frames));

`ifdef FRAME_IRQ_EN
    checkOutput("irq_set", 96'(irq), 96'h1);
    rd_reg(9'h044, 32'h1);
    wr_reg(9'h044, 32'h0);
    checkOutput("irq_cleared", 96'(irq), 96'h0);
    rd_reg(9'h044, 32'h0);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 9'h044;
    writedata  = 32'h0;
    vcount     = 10'(VA);
    hcount     = 11'd0;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    exp_frames++;
    hcount = 11'd1;
    checkOutput("irq_set_wins", 96'(irq), 96'h1);
    @(negedge clk);
    vcount = 10'd100;
    hcount = 11'd10;
`else
    checkOutput("irq_tied_low", 96'(irq), 96'h0);
    wr_reg(9'h044, 32'h1);
    rd_reg(9'h044, 32'h0);
`endif

    // Reset mid-frame with a commit pending.
    wr_reg(9'h041, 32'h1);
    wr_reg(9'h000, 32'h3FF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0;
    checkOutput("mid_rst_sprite_x", 96'(sprite_x), 96'h0);
    checkOutput("mid_rst_sprite_y", 96'(sprite_y), 96'h0);
    checkOutput("mid_rst_sprite_en", 96'(sprite_en), 96'h0);
    checkOutput("mid_rst_readdata", 96'(readdata), 96'h0);
    checkOutput("mid_rst_irq", 96'(irq), 96'h0);
    rd_reg(9'h042, 32'h0);
    rd_reg(9'h041, 32'h2);
    rd_reg(9'h043, 32'h0);
    rd_reg(9'h000, 32'h0);

    idle(2);
    checkOutput("scoreboard_drained", 96'(exp_q.size()), 96'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
